load_store_unit: RTL and testbench

Core-side initiator for the data memory port. It accepts one load or store per request from the execute stage, with a byte address, RISC-V funct3 and store data. It drives the word-addressed, byte-strobed memory port (`memaccess`, `word_addr`, `wstrb`, `wdata`), then aligns and extends the returned `rdata`. It reports access and misalignment faults back to the core through a registered response pulse.

---
 rtl/riscv_defines.sv | 49 ++++
 rtl/load_align.sv | 29 ++
 rtl/load_store_unit.sv | 159 +++++++++++++++
 tb/tb_load_store_unit.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_defines.sv
// rtl/riscv_defines.sv - shared memory-port types, funct3 codes and LSU state encoding
package riscv_defines;

  typedef enum logic [1:0] {
    MEM_DISABLED = 2'd0,
    MEM_READ     = 2'd1,
    MEM_WRITE    = 2'd2
  } memaccess_t;

  // Size of data memory in 32-bit words; word addresses at or above fault.
  localparam int DMEM_WORD = 1024;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ISSUE    = 3'd1,
    WAIT     = 3'd2,
    ISSUE_HI = 3'd3,
    WAIT_HI  = 3'd4
  } lsu_state_t;

  // Byte-lane mask of the access size, before shifting to the offset.
  function automatic logic [3:0] f3_mask(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   f3_mask = 4'b0001;
      2'b01:   f3_mask = 4'b0011;
      default: f3_mask = 4'b1111;
    endcase
  endfunction

  function automatic logic f3_legal(input logic we, input logic [2:0] f3);
    if (we) f3_legal = (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
    else    f3_legal = (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
                       (f3 == F3_LBU) || (f3 == F3_LHU);
  endfunction

  function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] off);
    f3_misaligned = ((f3[1:0] == 2'b01) && off[0]) || ((f3[1:0] == 2'b10) && (off != 2'b00));
  endfunction

endpackage

// File: rtl/load_align.sv
// rtl/load_align.sv - extract and sign/zero-extend a load result from a {hi, lo} word pair
// Ports: hi_i/lo_i upper and lower memory words, off_i byte offset,
//        funct3_i load type, result_o extended load value.
module load_align
  import riscv_defines::*;
(
  input  logic [31:0] hi_i,
  input  logic [31:0] lo_i,
  input  logic [1:0]  off_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] result_o
);

  logic [31:0] sh;

  assign sh = 32'({hi_i, lo_i} >> {off_i, 3'b000});

  always_comb begin
    result_o = sh;
    case (funct3_i)
      F3_LB:   result_o = {{24{sh[7]}}, sh[7:0]};
      F3_LH:   result_o = {{16{sh[15]}}, sh[15:0]};
      F3_LBU:  result_o = {24'b0, sh[7:0]};
      F3_LHU:  result_o = {16'b0, sh[15:0]};
      default: result_o = sh;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - load/store unit driving a word-addressed, byte-strobed data memory port
// Ports: clk/rst; req_* request from execute (valid/ready handshake);
//        resp_* registered one-cycle response; memaccess/word_addr/wstrb/wdata
//        registered memory command; rdata/dmemfault memory return one cycle later.
// Build option: LSU_SPLIT_EN splits misaligned word-crossing accesses into two
//        memory accesses instead of rejecting misaligned requests.
module load_store_unit
  import riscv_defines::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_fault,
  output logic        resp_misaligned,
  output memaccess_t  memaccess,
  output logic [29:0] word_addr,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata,
  input  logic [31:0] rdata,
  input  logic        dmemfault
);

  lsu_state_t  state_q;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;
  logic [3:0]  req_strb;
  logic [31:0] req_wsh;
  logic [31:0] align_hi;
  logic [31:0] align_lo;
  logic [31:0] align_out;

  assign req_ready = (state_q == IDLE);

  // Low-word command is formed straight from the request so it can be
  // registered on the accept edge and appear during ISSUE.
  assign req_strb = f3_mask(req_funct3) << req_addr[1:0];
  assign req_wsh  = req_wdata << {req_addr[1:0], 3'b000};

`ifdef LSU_SPLIT_EN
  logic [29:0] word_q;
  logic [31:0] wdata_q;
  logic [31:0] lo_q;
  logic [3:0]  strb_hi;
  logic [31:0] wdata_hi;

  // Bytes spilling past lane 3 belong to the next word.
  assign strb_hi  = 4'(({4'b0, f3_mask(f3_q)} << off_q) >> 4);
  assign wdata_hi = 32'(({32'b0, wdata_q} << {off_q, 3'b000}) >> 32);
  assign align_hi = (state_q == WAIT_HI) ? rdata : 32'b0;
  assign align_lo = (state_q == WAIT_HI) ? lo_q  : rdata;
`else
  assign align_hi = 32'b0;
  assign align_lo = rdata;
`endif

  load_align u_load_align (
    .hi_i     (align_hi),
    .lo_i     (align_lo),
    .off_i    (off_q),
    .funct3_i (f3_q),
    .result_o (align_out)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= IDLE;
      we_q            <= 1'b0;
      f3_q            <= 3'b0;
      off_q           <= 2'b0;
      resp_valid      <= 1'b0;
      resp_rdata      <= 32'b0;
      resp_fault      <= 1'b0;
      resp_misaligned <= 1'b0;
      memaccess       <= MEM_DISABLED;
      word_addr       <= 30'b0;
      wstrb           <= 4'b0;
      wdata           <= 32'b0;
`ifdef LSU_SPLIT_EN
      word_q          <= 30'b0;
      wdata_q         <= 32'b0;
      lo_q            <= 32'b0;
`endif
    end else begin
      resp_valid <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            we_q  <= req_we;
            f3_q  <= req_funct3;
            off_q <= req_addr[1:0];
`ifdef LSU_SPLIT_EN
            word_q  <= req_addr[31:2];
            wdata_q <= req_wdata;
`endif
            if (!f3_legal(req_we, req_funct3)) begin
              resp_valid      <= 1'b1;
              resp_fault      <= 1'b1;
              resp_misaligned <= 1'b0;
              resp_rdata      <= 32'b0;
            end
`ifndef LSU_SPLIT_EN
            else if (f3_misaligned(req_funct3, req_addr[1:0])) begin
              resp_valid      <= 1'b1;
              resp_fault      <= 1'b0;
              resp_misaligned <= 1'b1;
              resp_rdata      <= 32'b0;
            end
`endif
            else begin
              state_q   <= ISSUE;
              memaccess <= req_we ? MEM_WRITE : MEM_READ;
              word_addr <= req_addr[31:2];
              wstrb     <= req_we ? req_strb : 4'b0;
              wdata     <= req_we ? req_wsh : 32'b0;
            end
          end
        end
        ISSUE, ISSUE_HI: begin
          state_q   <= (state_q == ISSUE) ? WAIT : WAIT_HI;
          memaccess <= MEM_DISABLED;
          word_addr <= 30'b0;
          wstrb     <= 4'b0;
          wdata     <= 32'b0;
        end
        WAIT, WAIT_HI: begin
`ifdef LSU_SPLIT_EN
          // A low-part fault skips the high part entirely.
          if (state_q == WAIT && !dmemfault &&
              ((({4'b0, f3_mask(f3_q)} << off_q) & 8'hF0) != 8'h00)) begin
            lo_q      <= rdata;
            state_q   <= ISSUE_HI;
            memaccess <= we_q ? MEM_WRITE : MEM_READ;
            word_addr <= word_q + 30'd1;
            wstrb     <= we_q ? strb_hi : 4'b0;
            wdata     <= we_q ? wdata_hi : 32'b0;
          end else
`endif
          begin
            state_q         <= IDLE;
            resp_valid      <= 1'b1;
            resp_fault      <= dmemfault;
            resp_misaligned <= 1'b0;
            resp_rdata      <= (dmemfault || we_q) ? 32'b0 : align_out;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed self-checking bench for load_store_unit
module tb_load_store_unit;
  import riscv_defines::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = 32'b0;
  logic [2:0]  req_funct3 = 3'b0;
  logic [31:0] req_wdata = 32'b0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_fault;
  logic        resp_misaligned;
  memaccess_t  memaccess;
  logic [29:0] word_addr;
  logic [3:0]  wstrb;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        dmemfault;

  int n_cmp = 0;
  int n_mis = 0;

  load_store_unit dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_funct3(req_funct3), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_fault(resp_fault),
    .resp_misaligned(resp_misaligned),
    .memaccess(memaccess), .word_addr(word_addr), .wstrb(wstrb), .wdata(wdata),
    .rdata(rdata), .dmemfault(dmemfault)
  );

  always #5 clk = ~clk;

  // Behavioural data memory with out-of-range fault.
  logic [31:0] mem [DMEM_WORD];
  always @(posedge clk) begin
    dmemfault <= 1'b0;
    if (memaccess != MEM_DISABLED) begin
      if (word_addr >= 30'(DMEM_WORD)) begin
        dmemfault <= 1'b1;
        rdata     <= 32'hDEADBEEF;
      end else if (memaccess == MEM_READ) begin
        rdata <= mem[word_addr[9:0]];
      end else begin
        for (int b = 0; b < 4; b++)
          if (wstrb[b]) mem[word_addr[9:0]][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  // Log of every memory command seen on the port.
  int          op_cnt = 0;
  memaccess_t  lg_ma [16];
  logic [29:0] lg_wa [16];
  logic [3:0]  lg_ws [16];
  logic [31:0] lg_wd [16];
  always @(negedge clk) begin
    if (memaccess != MEM_DISABLED) begin
      lg_ma[op_cnt[3:0]] = memaccess;
      lg_wa[op_cnt[3:0]] = word_addr;
      lg_ws[op_cnt[3:0]] = wstrb;
      lg_wd[op_cnt[3:0]] = wdata;
      op_cnt = op_cnt + 1;
    end
  end

  logic [31:0] r_rdata;
  logic        r_fault, r_mis, r_ready;
  int          r_lat, r_ops, r_base;
  logic [3:0]  i0, i1;

  // Called at a negedge with the LSU idle; returns at the response negedge.
  task automatic run(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                     input logic [31:0] wd);
    r_base = op_cnt;
    i0 = r_base[3:0];
    i1 = i0 + 4'd1;
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_addr = 32'hFFFF_FFFF; req_wdata = 32'h5A5A_5A5A; req_funct3 = 3'b111;
    r_lat = -1; r_rdata = 32'hX; r_fault = 1'bx; r_mis = 1'bx; r_ready = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (resp_valid) begin
        r_lat = c; r_rdata = resp_rdata; r_fault = resp_fault;
        r_mis = resp_misaligned; r_ready = req_ready;
        break;
      end
    end
    r_ops = op_cnt - r_base;
  endtask

  task automatic test_reset();
    #1;
    n_cmp++; if (memaccess !== MEM_DISABLED) begin n_mis++; $display("FAIL reset_memaccess got %0d want 0", memaccess); end
    n_cmp++; if (resp_valid !== 1'b0) begin n_mis++; $display("FAIL reset_resp_valid got %b want 0", resp_valid); end
    n_cmp++; if ({wstrb, word_addr, wdata, resp_rdata} !== 98'b0) begin n_mis++; $display("FAIL reset_port got %h/%h/%h/%h want 0", wstrb, word_addr, wdata, resp_rdata); end
    n_cmp++; if ({resp_fault, resp_misaligned} !== 2'b00) begin n_mis++; $display("FAIL reset_flags got %b%b want 00", resp_fault, resp_misaligned); end
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (req_ready !== 1'b1) begin n_mis++; $display("FAIL reset_ready got %b want 1", req_ready); end
  endtask

  task automatic test_word();
    run(1'b1, F3_SW, 32'h10, 32'h11223344);
    n_cmp++; if (r_ops !== 1 || lg_ma[i0] !== MEM_WRITE) begin n_mis++; $display("FAIL sw_cmd got ops %0d ma %0d want 1 op write", r_ops, lg_ma[i0]); end
    n_cmp++; if (lg_wa[i0] !== 30'd4 || lg_ws[i0] !== 4'b1111 || lg_wd[i0] !== 32'h11223344) begin n_mis++; $display("FAIL sw_port got %h %b %h want 4 1111 11223344", lg_wa[i0], lg_ws[i0], lg_wd[i0]); end
    n_cmp++; if (r_lat !== 3 || r_rdata !== 32'b0 || r_fault !== 1'b0) begin n_mis++; $display("FAIL sw_resp got lat %0d rd %h f %b want 3 0 0", r_lat, r_rdata, r_fault); end
    run(1'b0, F3_LW, 32'h10, 32'h0);
    n_cmp++; if (r_rdata !== 32'h11223344 || r_lat !== 3) begin n_mis++; $display("FAIL lw_data got %h lat %0d want 11223344 lat 3", r_rdata, r_lat); end
    n_cmp++; if (lg_ma[i0] !== MEM_READ || lg_ws[i0] !== 4'b0 || lg_wa[i0] !== 30'd4) begin n_mis++; $display("FAIL lw_port got %0d %b %h want read 0000 4", lg_ma[i0], lg_ws[i0], lg_wa[i0]); end
  endtask

  task automatic test_byte();
    run(1'b1, F3_SB, 32'h13, 32'hFFFFFFAB);
    n_cmp++; if (lg_ws[i0] !== 4'b1000 || lg_wd[i0] !== 32'hAB000000) begin n_mis++; $display("FAIL sb_port got %b %h want 1000 ab000000", lg_ws[i0], lg_wd[i0]); end
    run(1'b0, F3_LB, 32'h13, 32'h0);
    n_cmp++; if (r_rdata !== 32'hFFFFFFAB) begin n_mis++; $display("FAIL lb got %h want ffffffab", r_rdata); end
    run(1'b0, F3_LBU, 32'h13, 32'h0);
    n_cmp++; if (r_rdata !== 32'h000000AB) begin n_mis++; $display("FAIL lbu got %h want 000000ab", r_rdata); end
    run(1'b0, F3_LW, 32'h10, 32'h0);
    n_cmp++; if (r_rdata !== 32'hAB223344) begin n_mis++; $display("FAIL sb_merge got %h want ab223344", r_rdata); end
  endtask

  task automatic test_half();
    run(1'b1, F3_SW, 32'h10, 32'h80010000);
    run(1'b0, F3_LH, 32'h12, 32'h0);
    n_cmp++; if (r_rdata !== 32'hFFFF8001) begin n_mis++; $display("FAIL lh got %h want ffff8001", r_rdata); end
    run(1'b0, F3_LHU, 32'h12, 32'h0);
    n_cmp++; if (r_rdata !== 32'h00008001) begin n_mis++; $display("FAIL lhu got %h want 00008001", r_rdata); end
    run(1'b1, F3_SH, 32'h10, 32'hCAFE1234);
    n_cmp++; if (lg_ws[i0] !== 4'b0011 || lg_wd[i0] !== 32'hCAFE1234) begin n_mis++; $display("FAIL sh_port got %b %h want 0011 cafe1234", lg_ws[i0], lg_wd[i0]); end
    run(1'b0, F3_LW, 32'h10, 32'h0);
    n_cmp++; if (r_rdata !== 32'h80011234) begin n_mis++; $display("FAIL sh_merge got %h want 80011234", r_rdata); end
  endtask

  task automatic test_misaligned();
`ifdef LSU_SPLIT_EN
    run(1'b1, F3_SW, 32'h10, 32'h44332211);
    run(1'b1, F3_SW, 32'h14, 32'h88776655);
    run(1'b0, F3_LW, 32'h11, 32'h0);
    n_cmp++; if (r_ops !== 2 || lg_wa[i0] !== 30'd4 || lg_wa[i1] !== 30'd5) begin n_mis++; $display("FAIL split_lw_port got ops %0d wa %h %h want 2 4 5", r_ops, lg_wa[i0], lg_wa[i1]); end
    n_cmp++; if (r_rdata !== 32'h55443322 || r_lat !== 5 || r_mis !== 1'b0) begin n_mis++; $display("FAIL split_lw got %h lat %0d mis %b want 55443322 5 0", r_rdata, r_lat, r_mis); end
    run(1'b1, F3_SW, 32'h10, 32'h0);
    run(1'b1, F3_SW, 32'h0E, 32'hDDCCBBAA);
    n_cmp++; if (lg_ws[i0] !== 4'b1100 || lg_wa[i0] !== 30'd3 || lg_wd[i0] !== 32'hBBAA0000) begin n_mis++; $display("FAIL split_sw_lo got %b %h %h want 1100 3 bbaa0000", lg_ws[i0], lg_wa[i0], lg_wd[i0]); end
    n_cmp++; if (lg_ws[i1] !== 4'b0011 || lg_wa[i1] !== 30'd4 || lg_wd[i1] !== 32'h0000DDCC) begin n_mis++; $display("FAIL split_sw_hi got %b %h %h want 0011 4 0000ddcc", lg_ws[i1], lg_wa[i1], lg_wd[i1]); end
    run(1'b0, F3_LW, 32'h10, 32'h0);
    n_cmp++; if (r_rdata !== 32'h0000DDCC || r_lat !== 3) begin n_mis++; $display("FAIL split_lw_aligned got %h lat %0d want 0000ddcc 3", r_rdata, r_lat); end
    run(1'b0, F3_LW, 32'h0E, 32'h0);
    n_cmp++; if (r_rdata !== 32'hDDCCBBAA || r_lat !== 5) begin n_mis++; $display("FAIL split_lw_back got %h lat %0d want ddccbbaa 5", r_rdata, r_lat); end
    run(1'b0, F3_LH, 32'h11, 32'h0);
    n_cmp++; if (r_rdata !== 32'h000000DD || r_lat !== 3 || r_mis !== 1'b0) begin n_mis++; $display("FAIL inword_lh got %h lat %0d mis %b want 000000dd 3 0", r_rdata, r_lat, r_mis); end
`else
    run(1'b0, F3_LW, 32'h11, 32'h0);
    n_cmp++; if (r_ops !== 0 || r_lat !== 1) begin n_mis++; $display("FAIL mis_lw_timing got ops %0d lat %0d want 0 1", r_ops, r_lat); end
    n_cmp++; if (r_mis !== 1'b1 || r_rdata !== 32'b0 || r_fault !== 1'b0) begin n_mis++; $display("FAIL mis_lw_resp got mis %b rd %h f %b want 1 0 0", r_mis, r_rdata, r_fault); end
    run(1'b0, F3_LH, 32'h13, 32'h0);
    n_cmp++; if (r_mis !== 1'b1 || r_lat !== 1 || r_ops !== 0) begin n_mis++; $display("FAIL mis_lh got mis %b lat %0d ops %0d want 1 1 0", r_mis, r_lat, r_ops); end
    run(1'b1, F3_SW, 32'h12, 32'hFFFFFFFF);
    n_cmp++; if (r_mis !== 1'b1 || r_ops !== 0) begin n_mis++; $display("FAIL mis_sw got mis %b ops %0d want 1 0", r_mis, r_ops); end
    run(1'b0, F3_LW, 32'h10, 32'h0);
    n_cmp++; if (r_rdata !== 32'h80011234 || r_mis !== 1'b0) begin n_mis++; $display("FAIL mis_nowrite got %h mis %b want 80011234 0", r_rdata, r_mis); end
`endif
  endtask

  task automatic test_fault();
    run(1'b0, F3_LW, 32'h0000_1000, 32'h0);
    n_cmp++; if (r_fault !== 1'b1 || r_rdata !== 32'b0 || r_lat !== 3) begin n_mis++; $display("FAIL oob_lw got f %b rd %h lat %0d want 1 0 3", r_fault, r_rdata, r_lat); end
    run(1'b1, 3'b011, 32'h10, 32'h12345678);
    n_cmp++; if (r_fault !== 1'b1 || r_rdata !== 32'b0 || r_lat !== 1 || r_ops !== 0) begin n_mis++; $display("FAIL bad_store got f %b rd %h lat %0d ops %0d want 1 0 1 0", r_fault, r_rdata, r_lat, r_ops); end
    run(1'b0, 3'b110, 32'h10, 32'h0);
    n_cmp++; if (r_fault !== 1'b1 || r_lat !== 1 || r_ops !== 0) begin n_mis++; $display("FAIL bad_load got f %b lat %0d ops %0d want 1 1 0", r_fault, r_lat, r_ops); end
`ifdef LSU_SPLIT_EN
    run(1'b0, F3_LW, 32'h0000_0FFE, 32'h0);
    n_cmp++; if (r_fault !== 1'b1 || r_ops !== 2 || r_lat !== 5) begin n_mis++; $display("FAIL hi_fault got f %b ops %0d lat %0d want 1 2 5", r_fault, r_ops, r_lat); end
    run(1'b0, F3_LW, 32'h0000_1002, 32'h0);
    n_cmp++; if (r_fault !== 1'b1 || r_ops !== 1 || r_lat !== 3) begin n_mis++; $display("FAIL lo_fault got f %b ops %0d lat %0d want 1 1 3", r_fault, r_ops, r_lat); end
`endif
  endtask

  task automatic test_reset_mid();
    int seen;
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = F3_LW; req_addr = 32'h10;
    @(posedge clk); #1; req_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (memaccess !== MEM_READ) begin n_mis++; $display("FAIL mid_issue got %0d want read", memaccess); end
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_cmp++; if (memaccess !== MEM_DISABLED || req_ready !== 1'b1 || resp_valid !== 1'b0) begin n_mis++; $display("FAIL mid_reset got ma %0d rdy %b rv %b want 0 1 0", memaccess, req_ready, resp_valid); end
    @(negedge clk); rst = 1'b0;
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (resp_valid) seen++;
    end
    n_cmp++; if (seen !== 0) begin n_mis++; $display("FAIL mid_noresp got %0d responses want 0", seen); end
  endtask

  task automatic test_back_to_back();
    run(1'b1, F3_SW, 32'h20, 32'hA5A5F00D);
    n_cmp++; if (r_ready !== 1'b1) begin n_mis++; $display("FAIL b2b_ready got %b want 1", r_ready); end
    run(1'b0, F3_LW, 32'h20, 32'h0);
    n_cmp++; if (r_rdata !== 32'hA5A5F00D || r_lat !== 3) begin n_mis++; $display("FAIL b2b_lw got %h lat %0d want a5a5f00d 3", r_rdata, r_lat); end
    run(1'b0, F3_LBU, 32'h21, 32'h0);
    n_cmp++; if (r_rdata !== 32'h000000F0) begin n_mis++; $display("FAIL b2b_lbu got %h want 000000f0", r_rdata); end
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_misaligned();
    test_fault();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
